// File: rtl/slc3_sram_if.sv
// SLC-3 memory bus between the instruction sequencer (master) and the SRAM responder (slave).
// Carries the active-low strobes, the MAR/MDR data paths and the MMIO display and switch lines.
interface slc3_sram_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Data_in;
  logic              Mem_CE;
  logic              Mem_UB;
  logic              Mem_LB;
  logic              Mem_OE;
  logic              Mem_WE;
  logic [DATA_W-1:0] Data_out;
  logic              Data_valid;
  logic              Proto_err;
  logic [DATA_W-1:0] Hex_out;
  logic [DATA_W-1:0] Switches;

  modport master (
    output ADDR, Data_in, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Switches,
    input  Data_out, Data_valid, Proto_err, Hex_out
  );

  modport slave (
    input  ADDR, Data_in, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Switches,
    output Data_out, Data_valid, Proto_err, Hex_out
  );
endinterface

// File: rtl/slc3_sram_responder.sv
// Synchronous word-array SRAM model answering the SLC-3 active-low memory strobes with fixed latency.
// Define SLC3_SRAM_MMIO_EN to map the all-ones address to the Switches input and Hex_out register.
module slc3_sram_responder #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  slc3_sram_if.slave bus
);

  localparam int HALF    = DATA_W / 2;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int CNT_MAX = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_HOLD, WR_WAIT, WR_DONE} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              proto_err_q;
  logic              rd_load, wr_commit, proto_set, wr_en, mem_we;
  logic [DATA_W-1:0] rd_word, rd_lanes;

  // NOTE: the array has no reset so it maps onto block RAM and keeps its contents across Reset.
  logic [DATA_W-1:0] mem [DEPTH];

  // cnt counts strobe-low cycles already completed, so the IDLE cycle that starts an access is the first one.
  wire rd_req   = ~bus.Mem_CE & ~bus.Mem_OE & bus.Mem_WE;
  wire wr_req   = ~bus.Mem_CE & ~bus.Mem_WE;
  wire both_low = ~bus.Mem_CE & ~bus.Mem_OE & ~bus.Mem_WE;
  wire addr_chg = bus.ADDR != prev_addr;
  wire data_chg = bus.Data_in != prev_data;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (wr_req) begin
          if (cnt == WR_LAST) begin state_n = WR_DONE; cnt_n = '0; end
          else                begin state_n = WR_WAIT; cnt_n = cnt + 1'b1; end
        end else if (rd_req) begin
          if (cnt == RD_LAST) begin state_n = RD_HOLD; cnt_n = '0; end
          else                begin state_n = RD_WAIT; cnt_n = cnt + 1'b1; end
        end
      end
      RD_WAIT: begin
        if (!rd_req)              begin state_n = IDLE;    cnt_n = '0; end
        else if (cnt == RD_LAST)  begin state_n = RD_HOLD; cnt_n = '0; end
        else                      cnt_n = cnt + 1'b1;
      end
      RD_HOLD: begin
        if (!rd_req)       begin state_n = IDLE;    cnt_n = '0; end
        else if (addr_chg) begin state_n = RD_WAIT; cnt_n = '0; end
      end
      WR_WAIT: begin
        if (!wr_req)                  begin state_n = IDLE;    cnt_n = '0; end
        else if (addr_chg | data_chg) cnt_n = '0;
        else if (cnt == WR_LAST)      begin state_n = WR_DONE; cnt_n = '0; end
        else                          cnt_n = cnt + 1'b1;
      end
      WR_DONE: begin
        if (!wr_req) begin state_n = IDLE; cnt_n = '0; end
      end
      default: begin state_n = IDLE; cnt_n = '0; end
    endcase
  end

  always_comb begin
    rd_load   = 1'b0;
    wr_commit = 1'b0;
    proto_set = both_low;
    unique case (state)
      IDLE: begin
        rd_load   = rd_req & (cnt == RD_LAST);
        wr_commit = wr_req & (cnt == WR_LAST);
      end
      RD_WAIT: rd_load = rd_req & (cnt == RD_LAST);
      WR_WAIT: begin
        if (wr_req) begin
          if (addr_chg | data_chg) proto_set = 1'b1;
          else                     wr_commit = (cnt == WR_LAST);
        end
      end
      default: ;
    endcase
  end

  // A write pending while Reset is high is dropped rather than committed.
  assign wr_en = wr_commit & ~Reset;

  always_comb begin
    rd_lanes               = '0;
    rd_lanes[DATA_W-1:HALF] = bus.Mem_UB ? '0 : rd_word[DATA_W-1:HALF];
    rd_lanes[HALF-1:0]      = bus.Mem_LB ? '0 : rd_word[HALF-1:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prev_addr    <= '0;
      prev_data    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      prev_addr    <= bus.ADDR;
      prev_data    <= bus.Data_in;
      data_valid_q <= (state_n == RD_HOLD);
      if (rd_load)   data_out_q  <= rd_lanes;
      if (proto_set) proto_err_q <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      if (!bus.Mem_UB) mem[bus.ADDR][DATA_W-1:HALF] <= bus.Data_in[DATA_W-1:HALF];
      if (!bus.Mem_LB) mem[bus.ADDR][HALF-1:0]      <= bus.Data_in[HALF-1:0];
    end
  end

`ifdef SLC3_SRAM_MMIO_EN
  logic              io_hit;
  logic [DATA_W-1:0] hex_q;

  assign io_hit  = &bus.ADDR;
  assign rd_word = io_hit ? bus.Switches : mem[bus.ADDR];
  assign mem_we  = wr_en & ~io_hit;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hex_q <= '0;
    end else if (wr_en && io_hit) begin
      if (!bus.Mem_UB) hex_q[DATA_W-1:HALF] <= bus.Data_in[DATA_W-1:HALF];
      if (!bus.Mem_LB) hex_q[HALF-1:0]      <= bus.Data_in[HALF-1:0];
    end
  end

  assign bus.Hex_out = hex_q;
`else
  logic unused_switches;

  assign unused_switches = ^bus.Switches;
  assign rd_word         = mem[bus.ADDR];
  assign mem_we          = wr_en;
  assign bus.Hex_out     = '0;
`endif

  assign bus.Data_out   = data_out_q;
  assign bus.Data_valid = data_valid_q;
  assign bus.Proto_err  = proto_err_q;

endmodule

// File: tb/tb_slc3_sram_responder.sv
// Directed bench for slc3_sram_responder: a table of write/read transactions plus
// hand-written sequences for short reads, read hold, protocol errors, reset and the all-ones word.
module tb_slc3_sram_responder;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int RD_CYCLES = 2;
  localparam int WR_CYCLES = 2;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  always #5 Clk = ~Clk;

  slc3_sram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  slc3_sram_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_CYCLES(RD_CYCLES), .WR_CYCLES(WR_CYCLES)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef enum logic {OP_WR, OP_RD} op_t;

  typedef struct {
    op_t         op;
    logic [15:0] addr;
    logic [15:0] data;
    logic        ub;
    logic        lb;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [16];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic release_bus();
    bus.Mem_CE = 1'b1;
    bus.Mem_OE = 1'b1;
    bus.Mem_WE = 1'b1;
    bus.Mem_UB = 1'b0;
    bus.Mem_LB = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data,
                          input logic ub, input logic lb);
    @(negedge Clk);
    bus.ADDR    = addr;
    bus.Data_in = data;
    bus.Mem_UB  = ub;
    bus.Mem_LB  = lb;
    bus.Mem_CE  = 1'b0;
    bus.Mem_WE  = 1'b0;
    repeat (WR_CYCLES) @(negedge Clk);
    release_bus();
  endtask

  task automatic do_read(input logic [15:0] addr, input logic ub, input logic lb,
                         input logic [15:0] exp, input string name);
    @(negedge Clk);
    bus.ADDR   = addr;
    bus.Mem_UB = ub;
    bus.Mem_LB = lb;
    bus.Mem_CE = 1'b0;
    bus.Mem_OE = 1'b0;
    repeat (RD_CYCLES - 1) @(negedge Clk);
    check({name, " valid early"}, 32'(bus.Data_valid), 32'd0);
    @(negedge Clk);
    check({name, " valid"}, 32'(bus.Data_valid), 32'd1);
    check({name, " data"}, 32'(bus.Data_out), 32'(exp));
    release_bus();
  endtask

  initial begin
    vecs[0]  = '{OP_WR, 16'h0010, 16'h1234, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{OP_RD, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h1234};
    vecs[2]  = '{OP_WR, 16'h0020, 16'hFFFF, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{OP_WR, 16'h0020, 16'hAB00, 1'b0, 1'b1, 16'h0000};
    vecs[4]  = '{OP_RD, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'hABFF};
    vecs[5]  = '{OP_RD, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h00FF};
    vecs[6]  = '{OP_RD, 16'h0020, 16'h0000, 1'b0, 1'b1, 16'hAB00};
    vecs[7]  = '{OP_RD, 16'h0020, 16'h0000, 1'b1, 1'b1, 16'h0000};
    vecs[8]  = '{OP_WR, 16'h0021, 16'h1111, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{OP_WR, 16'h0021, 16'h2277, 1'b1, 1'b0, 16'h0000};
    vecs[10] = '{OP_RD, 16'h0021, 16'h0000, 1'b0, 1'b0, 16'h1177};
    vecs[11] = '{OP_WR, 16'h0000, 16'hCAFE, 1'b0, 1'b0, 16'h0000};
    vecs[12] = '{OP_RD, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hCAFE};
    vecs[13] = '{OP_WR, 16'hFFFE, 16'h0BAD, 1'b0, 1'b0, 16'h0000};
    vecs[14] = '{OP_RD, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 16'h0BAD};
    vecs[15] = '{OP_RD, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h1234};

    release_bus();
    bus.ADDR     = '0;
    bus.Data_in  = '0;
    bus.Switches = 16'h0F0F;

    // Reset values
    repeat (2) @(negedge Clk);
    check("reset Data_out", 32'(bus.Data_out), 32'h0);
    check("reset Data_valid", 32'(bus.Data_valid), 32'h0);
    check("reset Proto_err", 32'(bus.Proto_err), 32'h0);
    check("reset Hex_out", 32'(bus.Hex_out), 32'h0);
    Reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].op == OP_WR)
        do_write(vecs[i].addr, vecs[i].data, vecs[i].ub, vecs[i].lb);
      else
        do_read(vecs[i].addr, vecs[i].ub, vecs[i].lb, vecs[i].exp, $sformatf("vec%0d", i));
    end
    @(negedge Clk);
    check("clean traffic Proto_err", 32'(bus.Proto_err), 32'h0);

    // Single OE-low cycle: no data, FSM back to IDLE
    bus.ADDR   = 16'h0010;
    bus.Mem_CE = 1'b0;
    bus.Mem_OE = 1'b0;
    @(negedge Clk);
    check("short read valid", 32'(bus.Data_valid), 32'h0);
    release_bus();
    @(negedge Clk);
    check("short read idle valid", 32'(bus.Data_valid), 32'h0);
    check("short read Data_out kept", 32'(bus.Data_out), 32'h1234);
    do_read(16'h0010, 1'b0, 1'b0, 16'h1234, "after short");

    // Hold with OE low, then change ADDR mid-hold
    @(negedge Clk);
    bus.ADDR   = 16'h0010;
    bus.Mem_CE = 1'b0;
    bus.Mem_OE = 1'b0;
    repeat (RD_CYCLES) @(negedge Clk);
    check("hold valid", 32'(bus.Data_valid), 32'h1);
    @(negedge Clk);
    check("hold still valid", 32'(bus.Data_valid), 32'h1);
    check("hold data", 32'(bus.Data_out), 32'h1234);
    bus.ADDR = 16'h0000;
    @(negedge Clk);
    check("addr change drops valid", 32'(bus.Data_valid), 32'h0);
    repeat (RD_CYCLES) @(negedge Clk);
    check("reread valid", 32'(bus.Data_valid), 32'h1);
    check("reread data", 32'(bus.Data_out), 32'hCAFE);
    release_bus();
    @(negedge Clk);
    check("release valid", 32'(bus.Data_valid), 32'h0);
    check("release Data_out kept", 32'(bus.Data_out), 32'hCAFE);

    // OE and WE low together: write wins, Proto_err sticks
    bus.ADDR    = 16'h0030;
    bus.Data_in = 16'h5555;
    bus.Mem_CE  = 1'b0;
    bus.Mem_OE  = 1'b0;
    bus.Mem_WE  = 1'b0;
    repeat (WR_CYCLES) @(negedge Clk);
    release_bus();
    check("both low Proto_err", 32'(bus.Proto_err), 32'h1);
    do_read(16'h0030, 1'b0, 1'b0, 16'h5555, "both low mem");
    check("Proto_err sticky", 32'(bus.Proto_err), 32'h1);

    // Reset in the middle of a write: dropped, contents intact
    do_write(16'h0040, 16'h4444, 1'b0, 1'b0);
    @(negedge Clk);
    bus.ADDR    = 16'h0040;
    bus.Data_in = 16'h9999;
    bus.Mem_CE  = 1'b0;
    bus.Mem_WE  = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("midwrite reset Data_out", 32'(bus.Data_out), 32'h0);
    check("midwrite reset Data_valid", 32'(bus.Data_valid), 32'h0);
    check("midwrite reset Proto_err", 32'(bus.Proto_err), 32'h0);
    check("midwrite reset Hex_out", 32'(bus.Hex_out), 32'h0);
    @(negedge Clk);
    release_bus();
    @(negedge Clk);
    Reset = 1'b0;
    do_read(16'h0040, 1'b0, 1'b0, 16'h4444, "dropped write");
    do_read(16'h0010, 1'b0, 1'b0, 16'h1234, "survives reset");

    // Data_in change during WR_WAIT: Proto_err set, count restarts
    @(negedge Clk);
    bus.ADDR    = 16'h0060;
    bus.Data_in = 16'h1000;
    bus.Mem_CE  = 1'b0;
    bus.Mem_WE  = 1'b0;
    @(negedge Clk);
    check("before data change Proto_err", 32'(bus.Proto_err), 32'h0);
    bus.Data_in = 16'h2000;
    @(negedge Clk);
    check("data change Proto_err", 32'(bus.Proto_err), 32'h1);
    repeat (2) @(negedge Clk);
    release_bus();
    do_read(16'h0060, 1'b0, 1'b0, 16'h2000, "restarted write");

    // All-ones address
    do_write(16'hFFFF, 16'h00C3, 1'b0, 1'b0);
    @(negedge Clk);
`ifdef SLC3_SRAM_MMIO_EN
    check("mmio Hex_out", 32'(bus.Hex_out), 32'h00C3);
    do_read(16'hFFFF, 1'b0, 1'b0, 16'h0F0F, "mmio switches");
    do_read(16'hFFFF, 1'b1, 1'b0, 16'h000F, "mmio switches lb");
    do_write(16'hFFFF, 16'hAA00, 1'b0, 1'b1);
    @(negedge Clk);
    check("mmio Hex_out ub", 32'(bus.Hex_out), 32'hAAC3);
`else
    check("plain Hex_out", 32'(bus.Hex_out), 32'h0);
    do_read(16'hFFFF, 1'b0, 1'b0, 16'h00C3, "all-ones word");
`endif

    @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
